// File: rtl/gfx_float_to_fixed.sv
// IEEE-754 single to signed Q22.10 fixed converter.
// Three-stage valid/ready pipeline (unpack, shift, round/saturate); stalls collapse bubbles.
module gfx_float_to_fixed #(
    parameter int unsigned TAG_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_data,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_sat,
    output logic                 out_invalid
);

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MANT_W    = 24;
    localparam int unsigned MAG_W     = 31;
    localparam int unsigned K_W       = 9;
    localparam int unsigned RSH_W     = 25;
    localparam int unsigned EXT_W     = MANT_W + RSH_W;
    localparam int unsigned SHAMT_W   = 5;

    typedef enum logic [2:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_NAN,
        CLS_OVF,
        CLS_MIN
    } cls_t;

    // Stage-1 classification; exactly -2^21 is the one finite value that fits without clamping.
    function automatic cls_t classify_float(input logic sgn, input logic [7:0] e, input logic [22:0] m);
        cls_t c;
        if (e == 8'd0)
            c = CLS_ZERO;
        else if (e == 8'hFF)
            c = (m != 23'd0) ? CLS_NAN : CLS_OVF;
        else if (sgn && e == 8'd148 && m == 23'd0)
            c = CLS_MIN;
        else
            c = CLS_NORM;
        return c;
    endfunction

    logic v1, v2, v3;
    logic adv1, adv2, adv3;

    assign adv3      = ~v3 | out_ready;
    assign adv2      = ~v2 | adv3;
    assign adv1      = ~v1 | adv2;
    assign in_ready  = adv1;
    assign out_valid = v3;

    // Stage 1: unpack
    logic                  s1_sign;
    cls_t                  s1_cls;
    logic [MANT_W-1:0]     s1_mfull;
    logic signed [K_W-1:0] s1_k;
    logic [TAG_WIDTH-1:0]  s1_tag;

    logic signed [K_W-1:0] k_n;
    assign k_n = $signed({1'b0, in_data[30:23]}) - 9'sd140;

    always_ff @(posedge clk) begin
        if (adv1) begin
            s1_sign  <= in_data[31];
            s1_cls   <= classify_float(in_data[31], in_data[30:23], in_data[22:0]);
            s1_mfull <= {1'b1, in_data[22:0]};
            s1_k     <= k_n;
            s1_tag   <= in_tag;
        end
    end

    // Stage 2: align magnitude, extract guard and sticky
    cls_t               cls2_n;
    logic [MAG_W-1:0]   mag2_n;
    logic               guard2_n;
    logic               sticky2_n;
    logic [SHAMT_W-1:0] shamt;
    logic [EXT_W-1:0]   ext;

    always_comb begin
        cls2_n    = s1_cls;
        mag2_n    = '0;
        guard2_n  = 1'b0;
        sticky2_n = 1'b0;
        shamt     = SHAMT_W'(9'sd0 - s1_k);
        ext       = '0;
        if (s1_cls == CLS_NORM) begin
            if (s1_k > 9'sd7) begin
                cls2_n = CLS_OVF;
            end else if (s1_k >= 9'sd0) begin
                mag2_n = MAG_W'(s1_mfull) << s1_k[2:0];
            end else if (s1_k >= -9'sd25) begin
                ext       = {s1_mfull, RSH_W'(0)} >> shamt;
                mag2_n    = MAG_W'(ext[EXT_W-1:RSH_W]);
                guard2_n  = ext[RSH_W-1];
                sticky2_n = |ext[RSH_W-2:0];
            end else begin
                sticky2_n = 1'b1;
            end
        end
    end

    logic                 s2_sign;
    cls_t                 s2_cls;
    logic [MAG_W-1:0]     s2_mag;
    logic                 s2_guard;
    logic                 s2_sticky;
    logic [TAG_WIDTH-1:0] s2_tag;

    always_ff @(posedge clk) begin
        if (adv2) begin
            s2_sign   <= s1_sign;
            s2_cls    <= cls2_n;
            s2_mag    <= mag2_n;
            s2_guard  <= guard2_n;
            s2_sticky <= sticky2_n;
            s2_tag    <= s1_tag;
        end
    end

    // Stage 3: round to nearest even, apply sign, clamp
    logic [DATA_W-1:0] rounded;
    logic [DATA_W-1:0] res_data;
    logic              res_sat;
    logic              res_inv;

    always_comb begin
        rounded  = DATA_W'(s2_mag) + DATA_W'(s2_guard & (s2_sticky | s2_mag[0]));
        res_data = '0;
        res_sat  = 1'b0;
        res_inv  = 1'b0;
        unique case (s2_cls)
            CLS_NORM: res_data = s2_sign ? (DATA_W'(0) - rounded) : rounded;
            CLS_OVF: begin
                res_data = s2_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
                res_sat  = 1'b1;
            end
            CLS_MIN:  res_data = 32'h8000_0000;
            CLS_NAN:  res_inv  = 1'b1;
            default:  res_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            v3          <= 1'b0;
            out_data    <= '0;
            out_tag     <= '0;
            out_sat     <= 1'b0;
            out_invalid <= 1'b0;
        end else begin
            if (adv1) v1 <= in_valid;
            if (adv2) v2 <= v1;
            if (adv3) begin
                v3 <= v2;
                if (v2) begin
                    out_data    <= res_data;
                    out_tag     <= s2_tag;
                    out_sat     <= res_sat;
                    out_invalid <= res_inv;
                end
            end
        end
    end

endmodule

// File: doc/gfx_float_to_fixed.md
Name: gfx_float_to_fixed

Overview:
- Pipelined converter from IEEE-754 single `gfx::float` to signed Q22.10 `gfx::fixed`.
- Inverse direction of the fixed-to-float path. It feeds rasterizer/setup and fixed muladd units from shader float results.
- 3-stage pipeline with valid/ready on both sides, full throughput, and bubble collapse.
- An opaque tag travels with each datum, typically the lane index.

Parameters:
- TAG_WIDTH, 2, width of the sideband tag. The default covers SHADER_LANES=4.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input datum valid
- in_ready  out  1  converter accepts the datum this cycle
- in_data  in  32  float: sign, exp[7:0], mant[22:0]
- in_tag  in  TAG_WIDTH  sideband, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  32  Q22.10 fixed, two's complement
- out_tag  out  TAG_WIDTH  tag of out_data
- out_sat  out  1  result clamped (overflow or infinity)
- out_invalid  out  1  input was NaN

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: v1/v2/v3 cleared; out_valid=0, out_data=0, out_tag=0, out_sat=0, out_invalid=0. Datapath regs of stages 1-2 need no reset.
- Reset mid-operation: in-flight data is discarded and no output is produced.
- Handshake: a transfer happens when valid&ready are high in the same cycle.
  - Stage advance: adv3 = ~v3 | out_ready; adv2 = ~v2 | adv3; adv1 = ~v1 | adv2.
  - in_ready = adv1, combinational from out_ready, with no registered skid.
  - Once out_valid=1, out_data/tag/flags are held stable until accepted.
- Latency: accept in cycle N gives out_valid in cycle N+3 when out_ready is held 1. Throughput is 1/cycle.
- Stage 1 (classify/unpack):
  - Apply classify_float.
  - If exp==0: zero (denormals flush to 0, no flag).
  - If exp==255 and mant!=0: NaN.
  - If exp==255 and mant==0: Inf.
  - Otherwise mfull = {1,mant} (24b) and k = exp-140, signed 9b.
- Stage 2 (shift):
  - If k>=8: overflow.
  - If 0<=k<=7: mag = mfull<<k (31b); guard=sticky=0.
  - If -25<=k<0: s=-k; mag = mfull>>s; guard = mfull[s-1]; sticky = OR of mfull[s-2:0].
  - If k<-25: mag=0, guard=0, sticky=1.
- Stage 3 (round/sign/saturate):
  - RNE: mag += guard & (sticky | mag[0]). This cannot exceed 2^24 on the right-shift path.
  - Negate if sign.
  - Overflow/Inf: positive gives 0x7FFFFFFF, negative gives 0x80000000, out_sat=1.
  - Exception: a finite input of exactly -2^21 (0xCA000000) gives 0x80000000 with out_sat=0.
  - NaN: 0x00000000, out_invalid=1, out_sat=0.
  - Zero/denormal: 0x00000000. Negative zero also gives 0.
- Flags and tag are registered with the data in every stage.

Test Plan:
- 0x3F800000 (1.0) -> 0x00000400. 0xC0200000 (-2.5) -> 0xFFFFF600. Both with sat=0, invalid=0, latency 3.
- Rounding ties and sticky:
  - 0x3A000000 (2^-11, tie) -> 0x00000000, even.
  - 0x3AC00000 (1.5 LSB) -> 0x00000002.
  - 0x3AA00000 (1.25 LSB) -> 0x00000001.
  - 0x33800000 (2^-24) -> 0x00000000.
- Saturation and special inputs:
  - 0x501502F9 (1e10) -> 0x7FFFFFFF, sat=1.
  - 0xFF800000 (-inf) -> 0x80000000, sat=1.
  - 0xCA000000 -> 0x80000000, sat=0.
  - 0x7FC00000 -> 0x00000000, invalid=1.
  - 0x00000001 (denormal) -> 0, no flags.
- Streaming and backpressure:
  - Stream 8 values with tags 0..3 repeating while out_ready toggles randomly.
  - Required: results in order, no loss or duplication, tag matches, out_data stable while out_valid & ~out_ready.
  - With out_ready=0 for 5 cycles, exactly 3 items are accepted and then in_ready=0.
- Full throughput with bubbles: in_valid=1 continuously with out_ready=1 -> one result per cycle after 3-cycle fill. A single input bubble collapses when downstream is stalled.
- Reset mid-operation: assert rst_n=0 asynchronously, between clock edges, while 3 items are in flight. Required: out_valid drops immediately and out_data=0; after release, no stale result is emitted and the next input converts correctly.
